// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: state encodings, handshake
// levels and reset levels.
package div_unit_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    // Request levels driven by execute on start_i.
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // Levels of ready_o.
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Reset levels. The divider reset is active-low.
    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

endpackage

// File: rtl/div_unit.sv
// Iterative 32-step radix-2 restoring divider for DIV/DIVU.
// Result layout is {remainder, quotient}; both outputs are registered.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    div_state_t          state_reg, state_next;
    logic [2*DATA_W:0]   dividend_reg, dividend_next;
    logic [DATA_W-1:0]   divisor_reg, divisor_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                sign1_reg, sign1_next;
    logic                sign2_reg, sign2_next;
    logic                signed_op_reg, signed_op_next;
    logic [2*DATA_W-1:0] result_reg, result_next;
    logic                ready_reg, ready_next;

    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    // Operand magnitudes, partial-remainder trial subtract and final sign fix-up.
    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        diff    = {1'b0, dividend_reg[2*DATA_W-1:DATA_W]} - {1'b0, divisor_reg};
        quo_fix = (signed_op_reg && (sign1_reg ^ sign2_reg)) ?
                  -dividend_reg[DATA_W-1:0] : dividend_reg[DATA_W-1:0];
        rem_fix = (signed_op_reg && sign1_reg) ?
                  -dividend_reg[2*DATA_W:DATA_W+1] : dividend_reg[2*DATA_W:DATA_W+1];
    end

    // Next-state and datapath update; outputs default to idle (zero, not ready).
    always_comb begin
        state_next     = state_reg;
        dividend_next  = dividend_reg;
        divisor_next   = divisor_reg;
        cnt_next       = cnt_reg;
        sign1_next     = sign1_reg;
        sign2_next     = sign2_reg;
        signed_op_next = signed_op_reg;
        result_next    = '0;
        ready_next     = DivResultNotReady;
        unique case (state_reg)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_next = DivByZero;
                    end else begin
                        state_next     = DivOn;
                        dividend_next  = {{DATA_W{1'b0}}, op1_abs, 1'b0};
                        divisor_next   = op2_abs;
                        sign1_next     = opdata1_i[DATA_W-1];
                        sign2_next     = opdata2_i[DATA_W-1];
                        signed_op_next = signed_div_i;
                        cnt_next       = '0;
                    end
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else begin
                    dividend_next = '0;
                    state_next    = DivEnd;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_next = DivFree;
                    cnt_next   = '0;
                end else if (cnt_reg != CNT_W'(DATA_W)) begin
                    // Restore (plain shift) when the trial subtract underflows.
                    if (diff[DATA_W]) begin
                        dividend_next = {dividend_reg[2*DATA_W-1:0], 1'b0};
                    end else begin
                        dividend_next = {diff[DATA_W-1:0], dividend_reg[DATA_W-1:0], 1'b1};
                    end
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    // Final step: present the fixed result on this same edge.
                    dividend_next = {rem_fix, 1'b0, quo_fix};
                    cnt_next      = '0;
                    state_next    = DivEnd;
                    result_next   = {rem_fix, quo_fix};
                    ready_next    = DivResultReady;
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    state_next = DivFree;
                end else begin
                    result_next = {dividend_reg[2*DATA_W:DATA_W+1], dividend_reg[DATA_W-1:0]};
                    ready_next  = DivResultReady;
                end
            end
            default: state_next = DivFree;
        endcase
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_reg     <= DivFree;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            cnt_reg       <= '0;
            sign1_reg     <= 1'b0;
            sign2_reg     <= 1'b0;
            signed_op_reg <= 1'b0;
            result_reg    <= '0;
            ready_reg     <= DivResultNotReady;
        end else begin
            state_reg     <= state_next;
            dividend_reg  <= dividend_next;
            divisor_reg   <= divisor_next;
            cnt_reg       <= cnt_next;
            sign1_reg     <= sign1_next;
            sign2_reg     <= sign2_next;
            signed_op_reg <= signed_op_next;
            result_reg    <= result_next;
            ready_reg     <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of divisions plus annul, async-reset
// and operand-scramble sequences.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // One full transaction: accept, wait for ready, hold one edge, drop start.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input int lat,
                          input bit scramble, input string name);
        int edges;
        bit ok;
        edges = 0;
        ok = 0;
        @(negedge clk);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o) begin
                edges = i;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check({name, "_timeout"}, 65'd0, 65'd1);
        end else begin
            check({name, "_latency"}, 65'(edges), 65'(lat));
            check({name, "_result"}, {1'b0, result_o}, {1'b0, r, q});
            @(posedge clk);
            #1;
            check({name, "_hold"}, {ready_o, result_o}, {1'b1, r, q});
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_drop"}, {ready_o, result_o}, 65'd0);
    endtask

    initial begin
        int highs;
        bit ok;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #3;
        check("reset", {ready_o, result_o}, 65'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   34};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          34};
        vecs[3]  = '{1'b0, 32'h1234,       32'd0,          32'd0,          32'd0,          3};
        vecs[4]  = '{1'b1, 32'h1234,       32'd0,          32'd0,          32'd0,          3};
        vecs[5]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   34};
        vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   34};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          34};
        vecs[8]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          34};
        vecs[9]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          34};
        vecs[10] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          34};

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
        end

        // Annul at iteration 10: no result may ever appear.
        highs = 0;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) highs++;
        end
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) highs++;
        end
        check("annul_no_ready", 65'(highs), 65'd0);
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 34, 1'b0, "after_annul");

        // Operands change every cycle after accept; only accept values count.
        run_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34, 1'b1, "scramble");

        // Async reset mid-operation, between clock edges.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (19) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_mid", {ready_o, result_o}, 65'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) highs++;
        end
        check("async_mid_no_ready", 65'(highs), 65'd0);

        // Async reset while a result is being presented clears it without a clock edge.
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                ok = 1;
                break;
            end
        end
        check("async_end_ready", {64'd0, ok}, 65'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_end", {ready_o, result_o}, 65'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 34, 1'b0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
